// File: rtl/fixed_point_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_mul_arbiter
// Description : Round-robin arbiter sharing one signed fixed-point multiplier
//               between NREQ requesters. The winner's operands are multiplied
//               at full precision, converted to WOI.WOF with truncation or
//               round-to-nearest plus saturation, and returned through one
//               registered, back-pressurable result port tagged with the
//               requester index.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               req_valid/req_ready  - per-requester handshake (NREQ bits)
//               req_a/req_b          - packed operands, requester i in slice i
//               out_valid/out_ready  - result handshake
//               out_id               - index of the requester owning the result
//               out, out_overflow    - converted result and saturation flag
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*(WIIA+WIFA)-1:0]   req_a,
    input  logic [NREQ*(WIIB+WIFB)-1:0]   req_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IW-1:0]                 out_id,
    output logic [WOI+WOF-1:0]            out,
    output logic                          out_overflow
);

    localparam int c_WA = WIIA + WIFA;
    localparam int c_WB = WIIB + WIFB;
    localparam int c_WP = c_WA + c_WB;
    localparam int c_PI = WIIA + WIIB;
    localparam int c_PF = WIFA + WIFB;
    localparam int c_WO = WOI + WOF;
    // Working width: wide enough for the product, the rounding bias, any
    // left shift, and a guard bit above the output range for the fit test.
    localparam int c_WV = c_PI + c_PF + WOI + WOF + 2;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [IW-1:0]   r_ptr;
    logic            r_out_valid;
    logic [IW-1:0]   r_out_id;
    logic [c_WO-1:0] r_out;
    logic            r_out_overflow;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic            w_slot_free;
    logic            w_hit_hi;
    logic [IW-1:0]   w_idx_hi;
    logic            w_hit_any;
    logic [IW-1:0]   w_idx_any;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_grant;
    logic [IW-1:0]   w_ptr_next;

    assign w_slot_free = ~r_out_valid | out_ready;

    // Round-robin search as two priority encoders: the lowest valid index at
    // or above ptr wins; if there is none, the search has wrapped and the
    // lowest valid index overall wins.
    always_comb begin
        w_hit_hi  = 1'b0;
        w_idx_hi  = '0;
        w_hit_any = 1'b0;
        w_idx_any = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                w_hit_any = 1'b1;
                w_idx_any = IW'(j);
                if (IW'(j) >= r_ptr) begin
                    w_hit_hi = 1'b1;
                    w_idx_hi = IW'(j);
                end
            end
        end
    end

    assign w_gnt_idx  = w_hit_hi ? w_idx_hi : w_idx_any;
    assign w_grant    = w_slot_free & w_hit_any & ~rst;
    assign req_ready  = w_grant ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_ptr_next = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // ------------------------------------------------------------------
    // Operand selection and full-precision product
    // ------------------------------------------------------------------
    logic [c_WA-1:0]        w_sel_a;
    logic [c_WB-1:0]        w_sel_b;
    logic signed [c_WP-1:0] w_a_ext;
    logic signed [c_WP-1:0] w_b_ext;
    logic signed [c_WP-1:0] w_prod;
    logic signed [c_WV-1:0] w_prod_ext;
    logic signed [c_WV-1:0] w_scaled;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (IW'(j) == w_gnt_idx) begin
                w_sel_a = req_a[j*c_WA +: c_WA];
                w_sel_b = req_b[j*c_WB +: c_WB];
            end
        end
    end

    assign w_a_ext    = c_WP'($signed(w_sel_a));
    assign w_b_ext    = c_WP'($signed(w_sel_b));
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = c_WV'(w_prod);

    // ------------------------------------------------------------------
    // Fraction conversion: widen with zeros or drop bits
    // ------------------------------------------------------------------
    generate
        if (WOF >= c_PF) begin : g_frac_ext
            assign w_scaled = w_prod_ext <<< (WOF - c_PF);
        end else begin : g_frac_red
            localparam int c_D = c_PF - WOF;
            localparam logic [c_WV-1:0] c_ONE = c_WV'(1);
            // Half an output LSB; adding it before the arithmetic shift gives
            // round-half-up, leaving it zero gives truncation toward -inf.
            localparam logic signed [c_WV-1:0] c_BIAS =
                (ROUND != 0) ? $signed(c_ONE << (c_D - 1)) : '0;
            assign w_scaled = (w_prod_ext + c_BIAS) >>> c_D;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Integer conversion with saturation
    // ------------------------------------------------------------------
    logic [c_WV-c_WO:0] w_hi;
    logic               w_fits;
    logic [c_WO-1:0]    w_conv;

    // The value fits when every bit from the output sign bit upward agrees.
    assign w_hi   = w_scaled[c_WV-1:c_WO-1];
    assign w_fits = (&w_hi) | ~(|w_hi);
    assign w_conv = w_fits             ? w_scaled[c_WO-1:0] :
                    w_scaled[c_WV-1]   ? {1'b1, {(c_WO-1){1'b0}}} :
                                         {1'b0, {(c_WO-1){1'b1}}};

    // ------------------------------------------------------------------
    // Result register and pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= '0;
            r_out_valid    <= 1'b0;
            r_out_id       <= '0;
            r_out          <= '0;
            r_out_overflow <= 1'b0;
        end else if (w_grant) begin
            r_ptr          <= w_ptr_next;
            r_out_valid    <= 1'b1;
            r_out_id       <= w_gnt_idx;
            r_out          <= w_conv;
            r_out_overflow <= ~w_fits;
        end else if (out_ready) begin
            // Drain with no refill: payload holds, only valid drops.
            r_out_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_id       = r_out_id;
    assign out          = r_out;
    assign out_overflow = r_out_overflow;

endmodule
`default_nettype wire

// File: doc/fixed_point_mul_arbiter.md
# fixed_point_mul_arbiter

Round-robin arbiter that shares one fixed-point multiplier between `NREQ` independent requesters. Each requester presents two signed fixed-point operands with a valid/ready handshake. The block grants at most one requester per cycle and multiplies its operands at full precision. It converts the product to the output format and returns it through a single registered, back-pressurable result port tagged with the requester index. It sits between several fixed-point consumers (filter taps, scalers) and the single multiplier resource that the datapath can afford.

## Interface
- `NREQ`, 4: number of requesters, ≥1.
- `WIIA`, 8: integer bits of operand A, including sign.
- `WIFA`, 8: fraction bits of operand A.
- `WIIB`, 8: integer bits of operand B, including sign.
- `WIFB`, 8: fraction bits of operand B.
- `WOI`, 8: integer bits of the result, including sign.
- `WOF`, 8: fraction bits of the result.
- `ROUND`, 1: 1 = round to nearest when dropping fraction bits; 0 = truncate.
- Derived: `IW` = max(1, $clog2(NREQ)).

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i holds an operand pair.
- `req_ready`  out  NREQ  bit i: requester i granted this cycle; a transfer occurs when valid and ready are both high.
- `req_a`  in  NREQ*(WIIA+WIFA)  operand A, packed; requester i occupies slice i.
- `req_b`  in  NREQ*(WIIB+WIFB)  operand B, packed; requester i occupies slice i.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  downstream accepts the result.
- `out_id`  out  IW  index of the requester that owns the result.
- `out`  out  WOI+WOF  signed result in WOI.WOF format.
- `out_overflow`  out  1  result saturated.

## Operation
- **Arithmetic.** Full product = signed(a) × signed(b), in (WIIA+WIIB).(WIFA+WIFB) format.
- **Fraction conversion.** Fraction bits are extended with zeros, or reduced by truncation or by rounding (when `ROUND`=1). This matches the team's fixed-point zoom block.
- **Integer conversion.** If the value does not fit WOI integer bits, `out` saturates to the most positive or most negative code and `out_overflow`=1. Otherwise `out_overflow`=0.
- **Slot availability.** `slot_free` = !out_valid || out_ready.
- **Arbitration.** When `slot_free`=1, the first requester i with `req_valid[i]`=1 wins. The search starts at `ptr` and proceeds in increasing index order, wrapping modulo NREQ. Only the winner sees `req_ready` high.
- **Stall.** If `slot_free`=0, all `req_ready`=0.
- **Combinational paths.** `req_ready` depends combinationally on `req_valid`, `ptr`, `out_valid` and `out_ready`. A requester must not make `req_valid` depend on `req_ready`.
- **On a grant to i:**
  - the result register loads the converted product, `out_id` <= i, `out_valid` <= 1;
  - `ptr` <= (i+1) mod NREQ.
- **Drain without refill.** When `out_valid` && `out_ready` and there is no grant, `out_valid` <= 0. `out`, `out_id` and `out_overflow` hold their values.
- **No grant.** `ptr` is unchanged.
- **Stability.** While `out_valid`=1 && `out_ready`=0, `out`, `out_id` and `out_overflow` are stable.
- **Fairness.** A continuously valid requester is granted within NREQ grants.
- **NREQ=1.** `ptr` stays 0, `out_id`=0, and the requester is granted whenever `slot_free`=1.

## Timing
- **Reset values.** `out_valid`=0, `out`=0, `out_id`=0, `out_overflow`=0, `ptr`=0. `req_ready`=0 while `rst`=1.
- **Reset mid-operation.** Any held result is discarded, and no grant is issued in the reset cycle.
- **Latency.** A grant in cycle t produces `out_valid`=1 with the result in cycle t+1.
- **Throughput.** One result per cycle while `out_ready`=1 and requests are present.
- **Simultaneous accept and grant.** A result accepted in cycle t can be replaced in the same edge by the cycle-t grant, with no bubble.
- **Back-pressure.** With `out_ready`=0 and `out_valid`=1, no grant occurs and `ptr` holds.
- **Pointer wrap.** `ptr`=NREQ-1 followed by a grant to NREQ-1 gives `ptr`=0.

## Test plan
- **Reset.** Hold `rst` 3 cycles with all `req_valid`=1 -> all `req_ready`=0, `out_valid`=0, `out`=0. Release -> requester 0 is granted first.
- **Basic product.** Single request, default params, a=0x0180 (1.5), b=0x0200 (2.0) -> next cycle `out`=0x0300, `out_overflow`=0. Then a=0xFF00 (-1.0), b=0x0080 (0.5) -> `out`=0xFF80.
- **Saturation.** a=b=0x6400 (100.0) -> `out`=0x7FFF, `out_overflow`=1. a=0x6400, b=0x9C00 (-100.0) -> `out`=0x8000, `out_overflow`=1.
- **Round-robin.** NREQ=4, all valid continuously, `out_ready`=1 -> `out_id` sequence 0,1,2,3,0,1,… one per cycle. Drop `req_valid[2]` -> sequence 0,1,3,0,1,3.
- **Back-pressure.** `out_ready`=0 for 5 cycles while results are pending -> all `req_ready`=0, outputs stable, `ptr` held. Reassert -> the held result is accepted and the next grant is issued in the same cycle.
- **Rounding.** WOF=4, ROUND=1, a=0x0018 (0.09375), b=0x0100 (1.0) -> `out`=0x02 (0.125). With ROUND=0 -> `out`=0x01.
